// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the AHB requester arbiter.
package ahb_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  // Index width for n items, never less than 1 bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last, wrapping at N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] grant
);

  int            idx;
  logic [IW-1:0] ii;

  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = 0;
    ii    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      ii  = IW'(idx);
      if (!any && req[ii]) begin
        any   = 1'b1;
        grant = ii;
      end
    end
  end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter sharing one ahb_master port; one transaction in flight,
// completion status and read byte returned to the granted requester.
module ahb_req_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [32*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   rsp_done,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 m_read,
  output logic                 m_write,
  output logic [31:0]          m_addr,
  output logic [7:0]           m_wdata,
  input  logic [7:0]           m_rdata,
  input  logic                 m_valid,
  input  logic [1:0]           m_resp,
  input  logic                 m_busy
);

  localparam int IW = clog2(NUM_REQ);
  localparam int CW = clog2(ACK_TIMEOUT + 1);

  state_t        state;
  logic [IW-1:0] last_grant, grant, pick_idx;
  logic [CW-1:0] cnt;
  logic          pick_any, is_write;

  logic [31:0] addr_arr  [NUM_REQ];
  logic [7:0]  wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[32*g +: 32];
    assign wdata_arr[g] = req_wdata[8*g +: 8];
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .last  (last_grant),
    .any   (pick_any),
    .grant (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      grant      <= '0;
      cnt        <= '0;
      is_write   <= 1'b0;
      m_read     <= 1'b0;
      m_write    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      rsp_done   <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_done <= '0;
      m_read   <= 1'b0;
      m_write  <= 1'b0;
      case (state)
        // A busy master in IDLE means something is still draining; wait it out.
        S_IDLE: if (pick_any && !m_busy) begin
          grant      <= pick_idx;
          last_grant <= pick_idx;
          m_addr     <= addr_arr[pick_idx];
          m_wdata    <= wdata_arr[pick_idx];
          is_write   <= req_write[pick_idx];
          m_write    <= req_write[pick_idx];
          m_read     <= !req_write[pick_idx];
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (m_busy) begin
            state <= S_WAIT_DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(ACK_TIMEOUT - 1)) begin
              rsp_err         <= 1'b1;
              rsp_rdata       <= '0;
              rsp_done[grant] <= 1'b1;
              state           <= S_DONE;
            end
          end
        end
        S_WAIT_DONE: if (!m_busy) begin
          rsp_rdata       <= (!is_write && m_valid) ? m_rdata : 8'h00;
          rsp_err         <= (m_resp != HRESP_OKAY) || (!is_write && !m_valid);
          rsp_done[grant] <= 1'b1;
          state           <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Scoreboard bench: tests queue expected commands/responses, a monitor compares.
module tb_ahb_req_arbiter;

  localparam int NR = 2;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid = '0, req_write = '0;
  logic [32*NR-1:0] req_addr = '0;
  logic [8*NR-1:0]  req_wdata = '0;
  logic [NR-1:0]    rsp_done;
  logic [7:0]       rsp_rdata, m_wdata;
  logic             rsp_err, m_read, m_write;
  logic [31:0]      m_addr;
  logic [7:0]       m_rdata = '0;
  logic             m_valid = 1'b0, m_busy = 1'b0;
  logic [1:0]       m_resp = 2'b00;

  ahb_req_arbiter #(.NUM_REQ(NR), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_valid(m_valid), .m_resp(m_resp), .m_busy(m_busy)
  );

  typedef struct {logic wr; logic [31:0] addr; logic [7:0] wdata;} cmd_t;
  typedef struct {int idx; logic [7:0] rdata; logic err; int lat;} rsp_t;
  typedef struct {int waits; logic [7:0] rdata; logic [1:0] resp; logic valid; logic dead;} slv_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  slv_t slv_q[$];

  int n_cmp = 0, n_bad = 0;
  int left [NR];
  int cyc = 0, cmd_cyc = 0, n_done = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Requesters: hold req_valid while transactions remain, drop on seeing rsp_done.
  always @(negedge clk)
    for (int i = 0; i < NR; i++) begin
      if (rsp_done[i] && left[i] > 0) left[i]--;
      req_valid[i] = (left[i] > 0);
    end

  // ahb_master model: busy starts the cycle after the command, lasts 2+waits cycles.
  int   s_cnt = 0;
  slv_t cur;
  logic cur_rd = 1'b0;
  always @(negedge clk) begin
    if (!resetn) begin
      m_busy = 1'b0; m_valid = 1'b0; m_resp = 2'b00; s_cnt = 0;
    end else begin
      m_valid = 1'b0;
      m_resp  = 2'b00;
      if (s_cnt > 0) begin
        s_cnt--;
        if (s_cnt == 0) begin
          m_busy  = 1'b0;
          m_valid = cur_rd & cur.valid;
          m_rdata = cur.rdata;
          m_resp  = cur.resp;
        end
      end else if (m_read | m_write) begin
        if (slv_q.size() > 0) cur = slv_q.pop_front();
        else cur = '{0, 8'h00, 2'b00, 1'b1, 1'b0};
        cur_rd = m_read;
        if (!cur.dead) begin
          m_busy = 1'b1;
          s_cnt  = 2 + cur.waits;
        end
      end
    end
  end

  // Monitor
  logic prev_cmd = 1'b0, prev_done = 1'b0;
  cmd_t mc;
  rsp_t mr;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (prev_cmd)  check("cmd_pulse_width", {m_read, m_write}, 0);
    if (prev_done) check("done_pulse_width", rsp_done, 0);
    if (m_read | m_write) begin
      cmd_cyc = cyc;
      check("cmd_overlap_or_busy", {m_read & m_write, m_busy}, 0);
      if (cmd_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL cmd_unexpected: got read=%0b write=%0b addr=%0h, want no command", m_read, m_write, m_addr);
      end else begin
        mc = cmd_q.pop_front();
        check("m_write", m_write, mc.wr);
        check("m_read", m_read, !mc.wr);
        check("m_addr", m_addr, mc.addr);
        if (mc.wr) check("m_wdata", m_wdata, mc.wdata);
      end
    end
    if (rsp_done != 0) begin
      n_done++;
      if (rsp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp_unexpected: got rsp_done=%0b, want none", rsp_done);
      end else begin
        mr = rsp_q.pop_front();
        check("rsp_done_grant", rsp_done, 64'(1) << mr.idx);
        check("rsp_rdata", rsp_rdata, mr.rdata);
        check("rsp_err", rsp_err, mr.err);
        check("latency", cyc - cmd_cyc, mr.lat);
      end
    end
    prev_cmd  = m_read | m_write;
    prev_done = (rsp_done != 0);
  end

  // Queue one expected transaction; lat < 0 means it is expected never to complete.
  task automatic txn(input int i, input logic wr, input logic [31:0] a, input logic [7:0] wd,
                     input int waits, input logic [7:0] sd, input logic [1:0] resp,
                     input logic sv, input logic dead, input logic [7:0] er, input logic ee,
                     input int lat);
    slv_t s; cmd_t c; rsp_t r;
    s.waits = waits; s.rdata = sd; s.resp = resp; s.valid = sv; s.dead = dead;
    slv_q.push_back(s);
    c.wr = wr; c.addr = a; c.wdata = wd;
    cmd_q.push_back(c);
    if (lat >= 0) begin
      r.idx = i; r.rdata = er; r.err = ee; r.lat = lat;
      rsp_q.push_back(r);
    end
  endtask

  task automatic req(input int i, input logic wr, input logic [31:0] a, input logic [7:0] wd, input int n);
    req_write[i] = wr;
    req_addr[32*i +: 32] = a;
    req_wdata[8*i +: 8] = wd;
    left[i] = n;
  endtask

  task automatic wait_all(input string name, input int budget);
    int n = 0;
    while ((cmd_q.size() != 0 || rsp_q.size() != 0 || left[0] != 0 || left[1] != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: %0d cmd / %0d rsp still pending after %0d cycles", name, cmd_q.size(), rsp_q.size(), n);
      cmd_q.delete(); rsp_q.delete(); slv_q.delete();
      left[0] = 0; left[1] = 0;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, d0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {m_read, m_write, m_addr, m_wdata, rsp_done, rsp_rdata, rsp_err}, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single read from req0
    txn(0, 1'b0, 32'h2000_0001, 8'h00, 0, 8'hA5, 2'b00, 1'b1, 1'b0, 8'hA5, 1'b0, 3);
    req(0, 1'b0, 32'h2000_0001, 8'h00, 1);
    wait_all("t1", 100);

    // 2: write from req1 with 3 wait states
    txn(1, 1'b1, 32'h2000_0003, 8'h5C, 3, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 6);
    req(1, 1'b1, 32'h2000_0003, 8'h5C, 1);
    wait_all("t2", 100);

    // 3: both held for four transactions -> 0,1,0,1
    txn(0, 1'b0, 32'h2000_0010, 8'h00, 0, 8'h11, 2'b00, 1'b1, 1'b0, 8'h11, 1'b0, 3);
    txn(1, 1'b1, 32'h2000_0020, 8'h77, 1, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 4);
    txn(0, 1'b0, 32'h2000_0010, 8'h00, 0, 8'h22, 2'b00, 1'b1, 1'b0, 8'h22, 1'b0, 3);
    txn(1, 1'b1, 32'h2000_0020, 8'h77, 0, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 3);
    req(0, 1'b0, 32'h2000_0010, 8'h00, 2);
    req(1, 1'b1, 32'h2000_0020, 8'h77, 2);
    wait_all("t3", 200);

    // 4: dead master -> timeout error, ISSUE + ACK_TIMEOUT cycles after the command
    txn(0, 1'b0, 32'h2000_0040, 8'h00, 0, 8'h00, 2'b00, 1'b1, 1'b1, 8'h00, 1'b1, TO + 1);
    req(0, 1'b0, 32'h2000_0040, 8'h00, 1);
    wait_all("t4", 100);

    // 5: error response, then clean read, read without m_valid, write with error
    txn(1, 1'b0, 32'h2000_0050, 8'h00, 0, 8'h99, 2'b01, 1'b1, 1'b0, 8'h99, 1'b1, 3);
    req(1, 1'b0, 32'h2000_0050, 8'h00, 1);
    wait_all("t5a", 100);
    txn(1, 1'b0, 32'h2000_0051, 8'h00, 2, 8'h3C, 2'b00, 1'b1, 1'b0, 8'h3C, 1'b0, 5);
    req(1, 1'b0, 32'h2000_0051, 8'h00, 1);
    wait_all("t5b", 100);
    txn(0, 1'b0, 32'h2000_0052, 8'h00, 0, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 3);
    req(0, 1'b0, 32'h2000_0052, 8'h00, 1);
    wait_all("t5c", 100);
    txn(1, 1'b1, 32'h2000_0053, 8'hE1, 0, 8'h00, 2'b10, 1'b1, 1'b0, 8'h00, 1'b1, 3);
    req(1, 1'b1, 32'h2000_0053, 8'hE1, 1);
    wait_all("t5d", 100);

    // 6: reset during WAIT_DONE abandons the read; req0 then wins a tie first
    txn(0, 1'b0, 32'h2000_0060, 8'h00, 8, 8'hBB, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, -1);
    req(0, 1'b0, 32'h2000_0060, 8'h00, 1);
    n = 0;
    while (cmd_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL t6_cmd_timeout: command not issued after %0d cycles", n);
      cmd_q.delete();
    end
    repeat (3) @(negedge clk);
    d0 = n_done;
    #2 resetn = 1'b0;
    left[0] = 0;
    slv_q.delete();
    @(negedge clk);
    #2 resetn = 1'b1;
    check("reset_mid_txn_outputs", {m_read, m_write, m_addr, m_wdata, rsp_done, rsp_rdata, rsp_err}, 0);
    repeat (20) @(negedge clk);
    check("no_done_after_abort", n_done, d0);
    txn(0, 1'b0, 32'h2000_0070, 8'h00, 0, 8'h70, 2'b00, 1'b1, 1'b0, 8'h70, 1'b0, 3);
    txn(1, 1'b0, 32'h2000_0080, 8'h00, 0, 8'h80, 2'b00, 1'b1, 1'b0, 8'h80, 1'b0, 3);
    req(0, 1'b0, 32'h2000_0070, 8'h00, 1);
    req(1, 1'b0, 32'h2000_0080, 8'h00, 1);
    wait_all("t6", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
